// File: rtl/tuner_measure_ctrl.sv
// Measurement sequencer for the tuner: drains the codec FIFO, gates the zero-crossing counter for
// a fixed number of samples after a settle period, and latches the count for the display path.
module tuner_measure_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned GATE_SAMPLES = 48000,
  parameter int unsigned SETTLE       = 64,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             read_ready,
  output logic             read,
  output logic             cnt_clear,
  output logic             gate_en,
  output logic             sample_stb,
  input  logic [CNT_W-1:0] cnt_value,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             overrun,
  output logic             timeout_err,
  output logic             busy,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StSettle  = 3'd2,
    StGate    = 3'd3,
    StCapture = 3'd4,
    StHold    = 3'd5
  } state_e;

  localparam logic [15:0] GateLast   = 16'(GATE_SAMPLES - 1);
  localparam logic [15:0] SettleLast = 16'(SETTLE - 1);
  localparam logic [15:0] GapLast    = 16'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [15:0] samp_cnt;
  logic [15:0] gap_cnt;
  logic        in_window;

  assign in_window  = (state_q == StSettle) || (state_q == StGate);
  assign sample_stb = read & in_window;
  assign busy       = (state_q != StIdle);
  assign state      = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      read         <= 1'b0;
      cnt_clear    <= 1'b0;
      gate_en      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      samp_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      // FIFO is drained in every state; the strobe alternates so it never repeats.
      read      <= read_ready & ~read;
      cnt_clear <= 1'b0;

      if (result_valid && result_ack) begin
        result_valid <= 1'b0;
      end

      if (in_window) begin
        gap_cnt <= sample_stb ? 16'd0 : gap_cnt + 16'd1;
      end

      if (abort) begin
        state_q <= StIdle;
        gate_en <= 1'b0;
      end else if (in_window && !sample_stb && (gap_cnt == GapLast)) begin
        timeout_err <= 1'b1;
        gate_en     <= 1'b0;
        state_q     <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q     <= StClear;
              cnt_clear   <= 1'b1;
              timeout_err <= 1'b0;
              overrun     <= 1'b0;
            end
          end
          StClear: begin
            samp_cnt <= '0;
            gap_cnt  <= '0;
            if (SETTLE == 0) begin
              state_q <= StGate;
              gate_en <= 1'b1;
            end else begin
              state_q <= StSettle;
            end
          end
          StSettle: begin
            if (sample_stb) begin
              if (samp_cnt == SettleLast) begin
                samp_cnt <= '0;
                state_q  <= StGate;
                gate_en  <= 1'b1;
              end else begin
                samp_cnt <= samp_cnt + 16'd1;
              end
            end
          end
          StGate: begin
            if (sample_stb) begin
              if (samp_cnt == GateLast) begin
                state_q <= StCapture;
                gate_en <= 1'b0;
              end else begin
                samp_cnt <= samp_cnt + 16'd1;
              end
            end
          end
          StCapture: begin
            result       <= cnt_value;
            result_valid <= 1'b1;
            // An ack landing this cycle retires the old result, so it is not an overrun.
            if (result_valid && !result_ack) begin
              overrun <= 1'b1;
            end
            state_q <= StHold;
          end
          StHold: begin
            if (continuous) begin
              state_q   <= StClear;
              cnt_clear <= 1'b1;
            end else if (result_ack) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tuner_measure_ctrl.sv
// Bench for tuner_measure_ctrl: directed tests with a capture scoreboard fed by the stimulus.
module tb_tuner_measure_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        continuous;
  logic        abort;
  logic        read_ready;
  logic        read;
  logic        cnt_clear;
  logic        gate_en;
  logic        sample_stb;
  logic [15:0] cnt_value;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ack;
  logic        overrun;
  logic        timeout_err;
  logic        busy;
  logic [2:0]  state;

  tuner_measure_ctrl #(
    .CNT_W       (16),
    .GATE_SAMPLES(8),
    .SETTLE      (2),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .continuous  (continuous),
    .abort       (abort),
    .read_ready  (read_ready),
    .read        (read),
    .cnt_clear   (cnt_clear),
    .gate_en     (gate_en),
    .sample_stb  (sample_stb),
    .cnt_value   (cnt_value),
    .result      (result),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .busy        (busy),
    .state       (state)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;
  int   rr_mode;
  int   ncyc, n_cap, n_clear, n_stb, gated, ungated, last_gated;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] res, input logic ovr);
    exp_t e;
    e.res = res;
    e.ovr = ovr;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  // Codec model: mode 1 = one-cycle read_ready every 20 clk, mode 2 = high for 20 clk.
  initial begin
    int rr_cnt;
    int hi_cnt;
    rr_cnt     = 0;
    hi_cnt     = 0;
    read_ready = 1'b0;
    forever begin
      step();
      if (rr_mode == 2) begin
        read_ready = (hi_cnt < 20);
        hi_cnt++;
      end else begin
        hi_cnt = 0;
        if (rr_mode == 1) begin
          read_ready = (rr_cnt == 0);
          rr_cnt     = (rr_cnt == 19) ? 0 : rr_cnt + 1;
        end else begin
          read_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: counts strobes per window and checks each capture against the scoreboard.
  initial begin
    logic [2:0] prev_state;
    exp_t       e;
    prev_state = 3'd0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!resetn) begin
        prev_state = 3'd0;
        gated      = 0;
        ungated    = 0;
      end else begin
        if (cnt_clear) begin
          gated   = 0;
          ungated = 0;
          n_clear++;
        end
        if (sample_stb) begin
          n_stb++;
          if (gate_en) begin
            gated++;
            last_gated = ncyc;
          end else begin
            ungated++;
          end
        end
        if (prev_state == 3'd4) begin
          n_cap++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_capture: got result %0d, expected no capture", result);
          end else begin
            e = exp_q.pop_front();
            check("cap_result", int'(result), int'(e.res));
            check("cap_valid", int'(result_valid), 1);
            check("cap_overrun", int'(overrun), int'(e.ovr));
            check("cap_gated_stbs", gated, 8);
            check("cap_settle_stbs", ungated, 2);
            check("cap_latency", ncyc - last_gated, 2);
          end
        end
        prev_state = state;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap0, clr0, stb0, n_rd, consec, stb_idle;
    logic prev_rd;
    resetn     = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    abort      = 1'b0;
    result_ack = 1'b0;
    cnt_value  = 16'd0;
    rr_mode    = 0;
    repeat (3) step();
    check("rst_state", int'(state), 0);
    check("rst_outputs", int'({read, cnt_clear, gate_en, sample_stb, result_valid, overrun,
                                timeout_err, busy}), 0);
    check("rst_result", int'(result), 0);
    resetn = 1'b1;
    repeat (2) step();

    // Test 2: read_ready held high 20 clk in IDLE -> 10 alternating reads, no counted samples.
    rr_mode  = 2;
    n_rd     = 0;
    consec   = 0;
    stb_idle = 0;
    prev_rd  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (read) n_rd++;
      if (read && prev_rd) consec++;
      if (sample_stb) stb_idle++;
      prev_rd = read;
    end
    check("t2_read_pulses", n_rd, 10);
    check("t2_consecutive", consec, 0);
    check("t2_idle_stb", stb_idle, 0);
    rr_mode = 0;
    step();

    // Test 1: single measurement.
    cap0      = n_cap;
    clr0      = n_clear;
    cnt_value = 16'd5;
    exp_q.push_back(mk_exp(16'd5, 1'b0));
    rr_mode = 1;
    pulse_start();
    check("t1_busy", int'(busy), 1);
    for (int i = 0; i < 400; i++) begin
      if (n_cap > cap0) break;
      step();
    end
    check("t1_captured", n_cap - cap0, 1);
    check("t1_hold", int'(state), 5);
    check("t1_clear_once", n_clear - clr0, 1);
    pulse_ack();
    check("t1_idle", int'(state), 0);
    check("t1_busy_after", int'(busy), 0);
    check("t1_valid_after", int'(result_valid), 0);

    // Test 3: samples stop after three -> timeout.
    stb0 = n_stb;
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      if (n_stb >= stb0 + 3) break;
      step();
    end
    rr_mode = 0;
    check("t3_three_stbs", n_stb - stb0, 3);
    repeat (85) step();
    check("t3_no_early_timeout", int'(timeout_err), 0);
    check("t3_still_gate", int'(state), 3);
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) break;
      step();
    end
    check("t3_timeout", int'(timeout_err), 1);
    check("t3_idle", int'(state), 0);
    check("t3_gate_off", int'(gate_en), 0);
    check("t3_result_kept", int'(result), 5);
    pulse_start();
    check("t3_timeout_cleared", int'(timeout_err), 0);
    check("t3_clear_state", int'(state), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_abort_idle", int'(state), 0);

    // Test 4: continuous mode, three windows without ack.
    cap0       = n_cap;
    continuous = 1'b1;
    cnt_value  = 16'd100;
    exp_q.push_back(mk_exp(16'd100, 1'b0));
    exp_q.push_back(mk_exp(16'd101, 1'b1));
    exp_q.push_back(mk_exp(16'd102, 1'b1));
    rr_mode = 1;
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 400; i++) begin
        if (n_cap > cap0 + w) break;
        step();
      end
      cnt_value = 16'(101 + w);
      if (w == 1) continuous = 1'b0;
    end
    check("t4_captures", n_cap - cap0, 3);
    check("t4_overrun_sticky", int'(overrun), 1);
    check("t4_hold", int'(state), 5);
    pulse_ack();
    check("t4_idle", int'(state), 0);
    check("t4_result", int'(result), 102);

    // Test 5: abort at the 4th gated sample, then start+abort together.
    clr0 = n_clear;
    pulse_start();
    check("t5_overrun_cleared", int'(overrun), 0);
    for (int i = 0; i < 400; i++) begin
      if (n_clear > clr0 && gated >= 4) break;
      step();
    end
    check("t5_reached_gate", int'(gate_en), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_idle", int'(state), 0);
    check("t5_abort_gate_off", int'(gate_en), 0);
    check("t5_abort_no_clear", int'(cnt_clear), 0);
    check("t5_result_kept", int'(result), 102);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort_idle", int'(state), 0);
    check("t5_start_abort_busy", int'(busy), 0);
    step();
    check("t5_start_abort_stays", int'(state), 0);

    // Test 6: asynchronous reset mid-GATE.
    clr0 = n_clear;
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (n_clear > clr0 && gated >= 2) break;
      step();
    end
    check("t6_in_gate", int'(state), 3);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_state", int'(state), 0);
    check("t6_async_outputs", int'({read, cnt_clear, gate_en, sample_stb, result_valid, overrun,
                                     timeout_err, busy}), 0);
    check("t6_async_result", int'(result), 0);
    repeat (2) @(negedge clk);
    #2;
    resetn  = 1'b1;
    rr_mode = 0;
    repeat (3) step();
    check("t6_post_idle", int'(state), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
